// File: rtl/dmem_arb_pkg.sv
// Shared defaults and types for the data-memory arbiter.
// The requester-id type is sized for the default requester count.
package dmem_arb_pkg;

  localparam int N_REQ_DEF  = 3;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 128;

  localparam int REQ_ID_W = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  // Requester that follows id in round-robin order.
  function automatic req_id_t next_req_id(input req_id_t id);
    if (int'(id) == N_REQ_DEF - 1) return '0;
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational masked priority picker: the lowest valid index at or above ptr wins,
// otherwise the lowest valid index overall; output is one-hot or zero.
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = REQ_ID_W
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && valid[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    // Wrap-around pass covers requesters below the pointer.
    for (int i = 0; i < N; i++) begin
      if (!found && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// N-requester single-port data memory arbiter; reads return one cycle after grant.
// Define DMEM_ARB_RR_EN for round-robin arbitration, otherwise fixed priority (lowest index wins).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] rd_pend;

`ifdef DMEM_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_id;

  rr_picker #(.N(N_REQ), .PW(ID_W)) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  // Winner drops to lowest priority; the pointer only moves on an actual grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end
`else
  rr_picker #(.N(N_REQ), .PW(ID_W)) u_picker (
    .valid (req_valid),
    .ptr   ('0),
    .grant (grant)
  );
`endif

  assign req_ready = rst ? '0 : grant;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        mem_we    = req_we[i];
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tracks which requester owns the read data arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= '0;
    end else begin
      rd_pend <= req_ready & ~req_we;
    end
  end

  assign rsp_valid = rd_pend;
  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 1-cycle-latency memory.
// Build with or without DMEM_ARB_RR_EN; expected grant orders follow the macro.
module tb_dmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  dmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] D_20 = 128'h2020_0000_0000_0000_0000_0000_0000_1111;
  localparam logic [DW-1:0] D_30 = 128'h3030_0000_0000_0000_0000_0000_0000_2222;

  logic [DW-1:0] mem [256];

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[8'h10] = D_A5;
    mem[8'h20] = D_20;
    mem[8'h30] = D_30;
    mem_rdata  = '0;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    int            at;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", DW'(rsp_valid), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", DW'(rsp_valid), DW'(e.v));
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_cycle", DW'(cyc), DW'(e.at));
      end
    end else if (sb.size() != 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rsp_missing", DW'(rsp_valid), DW'(e.v));
    end
  end

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  // Check one cycle's grant and memory command, queue any expected response, advance.
  task automatic step_chk(input string nm, input logic [N-1:0] er, input logic ewe,
                          input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                          input bit rd, input logic [DW-1:0] erd);
    @(negedge clk);
    chk({nm, "_ready"}, DW'(req_ready), DW'(er));
    chk({nm, "_mem_we"}, DW'(mem_we), DW'(ewe));
    if (er != '0) chk({nm, "_mem_addr"}, DW'(mem_addr), DW'(ea));
    if (ewe) chk({nm, "_mem_wdata"}, mem_wdata, ewd);
    if (rd) sb.push_back('{v: er, d: erd, at: cyc + 1});
    @(posedge clk);
    #1;
  endtask

`ifdef DMEM_ARB_RR_EN
  logic [N-1:0] arb_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [N-1:0] post_rst_g2 = 3'b010;
`else
  logic [N-1:0] arb_g [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [N-1:0] post_rst_g2 = 3'b001;
`endif

  function automatic logic [AW-1:0] addr_of(input logic [N-1:0] g);
    case (g)
      3'b001:  return 8'h10;
      3'b010:  return 8'h20;
      default: return 8'h30;
    endcase
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [N-1:0] g);
    case (g)
      3'b001:  return D_A5;
      3'b010:  return D_20;
      default: return D_30;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = 3'b111;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ready", DW'(req_ready), '0);
      chk("rst_mem_we", DW'(mem_we), '0);
      chk("rst_rsp_valid", DW'(rsp_valid), '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous contention from all three requesters, all reads.
    set_req(0, 1'b0, 8'h10, '0);
    set_req(1, 1'b0, 8'h20, '0);
    set_req(2, 1'b0, 8'h30, '0);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++)
      step_chk($sformatf("arb%0d", k), arb_g[k], 1'b0, addr_of(arb_g[k]), '0, 1'b1,
               data_of(arb_g[k]));

    req_valid = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ready", DW'(req_ready), '0);
      chk("idle_mem_we", DW'(mem_we), '0);
      chk("idle_rsp_valid", DW'(rsp_valid), '0);
      @(posedge clk);
      #1;
    end

    // Idle must not move the pointer: requester 0 wins next in either mode.
    req_valid = 3'b111;
    step_chk("post_idle", 3'b001, 1'b0, 8'h10, '0, 1'b1, D_A5);

    set_req(1, 1'b0, 8'h10, '0);
    req_valid = 3'b010;
    step_chk("single_rd", 3'b010, 1'b0, 8'h10, '0, 1'b1, D_A5);

    set_req(0, 1'b1, 8'hFF, 128'h1234);
    req_valid = 3'b001;
    step_chk("raw_wr", 3'b001, 1'b1, 8'hFF, 128'h1234, 1'b0, '0);
    set_req(2, 1'b0, 8'hFF, '0);
    req_valid = 3'b100;
    step_chk("raw_rd", 3'b100, 1'b0, 8'hFF, '0, 1'b1, 128'h1234);
    req_valid = '0;
    @(posedge clk);
    #1;

    // Read accepted, then reset in the following cycle: its response must vanish.
    set_req(1, 1'b0, 8'h20, '0);
    req_valid = 3'b010;
    step_chk("pre_rst_rd", 3'b010, 1'b0, 8'h20, '0, 1'b0, '0);
    rst = 1'b1;
    set_req(0, 1'b0, 8'h10, '0);
    req_valid = 3'b111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_rsp_valid", DW'(rsp_valid), '0);
      chk("midrst_ready", DW'(req_ready), '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    step_chk("post_rst0", 3'b001, 1'b0, 8'h10, '0, 1'b1, D_A5);
    step_chk("post_rst1", post_rst_g2, 1'b0, addr_of(post_rst_g2), '0, 1'b1,
             data_of(post_rst_g2));

    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", DW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the data memory.
REQ-002 Parameter ADDR_W, default 8: memory address width.
REQ-003 Parameter DATA_W, default 128: memory data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester access request.
REQ-007 req_ready  output  N_REQ  per-requester grant; transfer when valid&ready.
REQ-008 req_we  input  N_REQ  per-requester 1=write, 0=read.
REQ-009 req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  N_REQ*DATA_W  packed write data, same packing.
REQ-011 rsp_valid  output  N_REQ  one-hot read-data-valid pulse.
REQ-012 rsp_rdata  output  DATA_W  read data, shared by all requesters.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data: registered-address, 1-cycle read latency.

Function
REQ-017 At most one req_ready bit high per cycle; req_ready[i] high only if req_valid[i] high.
REQ-018 req_ready is combinational from req_valid and the arbitration state; it does not depend on req_ready of other blocks.
REQ-019 Granted requester's we/addr/wdata drive mem_we/mem_addr/mem_wdata in the same cycle; mem_we=req_we of the winner, 0 when no grant.
REQ-020 Each cycle with at least one valid request produces exactly one grant; no idle cycles under load.
REQ-021 Read accepted in cycle T: rsp_valid[i]=1 in cycle T+1 only, rsp_rdata=mem_rdata in T+1.
REQ-022 Writes produce no response.
REQ-023 Back-to-back reads from any requesters issue every cycle; responses follow in issue order, one per cycle.
REQ-024 Write in T then read of same address in T+1 returns the written data in T+2.
REQ-025 Responses have no backpressure; requesters accept rsp_valid unconditionally.
REQ-026 Requester keeps we/addr/wdata stable while valid&!ready; arbiter tolerates, but does not check, violations.
REQ-027 rsp_rdata is don't-care when no rsp_valid bit is set; it is driven from mem_rdata.

Reset
REQ-028 While rst high: req_ready=0, mem_we=0, rsp_valid=0, round-robin pointer=0, pending-response register cleared.
REQ-029 Read accepted in the cycle before rst asserts produces no rsp_valid after reset.
REQ-030 First cycle after rst deasserts: requester 0 has highest priority.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: round-robin; after a grant to i, priority order becomes i+1, i+2, ..., wrapping modulo N_REQ; pointer advances only on a grant.
REQ-032 Macro DMEM_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic is absent.

Structure
REQ-033 Package dmem_arb_pkg holds ADDR_W/DATA_W/N_REQ defaults and the requester-id type (width $clog2(N_REQ)).
REQ-034 Sub-module rr_picker: combinational masked priority picker (valid vector + pointer -> one-hot grant); the pointer register is held in dmem_arbiter.

Verification
REQ-035 Single read: req 1 reads addr 0x10 (mem holds 0xA5..A5) in T -> req_ready[1]=1 in T, rsp_valid=3'b010 and rsp_rdata=0xA5..A5 in T+1.
REQ-036 Round-robin (DMEM_ARB_RR_EN): all three valid continuously for 6 cycles -> grants 0,1,2,0,1,2.
REQ-037 Fixed priority (macro undefined): all three valid for 3 cycles -> grants 0,0,0; req 2 never ready.
REQ-038 RAW: req 0 writes 0x1234 at addr 0xFF in T, req 2 reads 0xFF in T+1 -> rsp_valid[2]=1, rsp_rdata=0x1234 in T+2.
REQ-039 Reset mid-read: read accepted in T, rst asserted in T+1 -> rsp_valid stays 0; after release, grant order restarts at requester 0.
REQ-040 Idle: no valid for 10 cycles -> mem_we=0, req_ready=0, rsp_valid=0 throughout; pointer unchanged.
